// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: per-slot blanking, frame-aligned double-buffered codes, cursor blink.
// Optional DISP_SCAN_DIM_EN adds a dim input that blanks the second half of every drive interval.
module disp_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int SLOT_CYC     = 50000,
  parameter int BLANK_CYC    = 64,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        mode,
  input  logic [3*N_DIGITS-1:0]       codes_in,
  input  logic                        update,
  input  logic [$clog2(N_DIGITS)-1:0] cursor,
`ifdef DISP_SCAN_DIM_EN
  input  logic                        dim,
`endif
  output logic [2:0]                  seg_code,
  output logic                        seg_en,
  output logic [N_DIGITS-1:0]         an_n,
  output logic                        frame_done
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_LEN  = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
`ifdef DISP_SCAN_DIM_EN
  localparam logic [CW-1:0] DIM_START  = CW'(BLANK_CYC + (SLOT_CYC - BLANK_CYC) / 2);
`endif

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [3*N_DIGITS-1:0] shadow_reg;
  logic [3*N_DIGITS-1:0] pending_reg;
  logic                  pending_valid_reg;
  logic [BW-1:0]         blink_cnt_reg;
  logic                  blink_on_reg;

  logic                  frame_end;
  logic                  frame_done_next;
  logic                  blink_mask;
  logic                  dim_mask;
  logic                  seg_en_next;
  logic [2:0]            seg_code_next;
  logic [2:0]            digit_code [N_DIGITS];
  logic [N_DIGITS-1:0]   an_n_next;

  // The current cycle is the last drive cycle of the last digit.
  assign frame_end = (state_reg == DRIVE) && (cnt_reg == SLOT_LAST) && (idx_reg == IDX_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      if (state_reg == IDLE) begin
        cnt_next = '0;
        idx_next = '0;
      end else if (cnt_reg == SLOT_LAST) begin
        cnt_next = '0;
        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
      // One slot counter spans blank and drive; the phase is a pure function of it.
      state_next = (cnt_next < BLANK_LEN) ? BLANK : DRIVE;
    end
  end

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      assign digit_code[gi] = shadow_reg[3*gi +: 3];
      assign an_n_next[gi]  = !((state_next == DRIVE) && (idx_next == IW'(gi)));
    end
  endgenerate

  always_comb begin
    frame_done_next = (state_next == DRIVE) && (cnt_next == SLOT_LAST) && (idx_next == IDX_LAST);
    blink_mask      = mode && !blink_on_reg && (idx_next == cursor);
`ifdef DISP_SCAN_DIM_EN
    dim_mask        = dim && (cnt_next >= DIM_START);
`else
    dim_mask        = 1'b0;
`endif
    seg_en_next     = (state_next == DRIVE) && !blink_mask && !dim_mask;
    seg_code_next   = (state_next == DRIVE) ? digit_code[idx_next] : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      an_n       <= '1;
      seg_en     <= 1'b0;
      seg_code   <= 3'b000;
      frame_done <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      an_n       <= an_n_next;
      seg_en     <= seg_en_next;
      seg_code   <= seg_code_next;
      frame_done <= frame_done_next;
    end
  end

  // Shadow only changes at frame boundaries while scanning, so a frame never shows mixed data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg        <= '0;
      pending_reg       <= '0;
      pending_valid_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (update) begin
        shadow_reg <= codes_in;
      end
    end else if (frame_end) begin
      if (update) begin
        shadow_reg <= codes_in;
      end else if (pending_valid_reg) begin
        shadow_reg <= pending_reg;
      end
      pending_valid_reg <= 1'b0;
    end else if (update) begin
      pending_reg       <= codes_in;
      pending_valid_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (!en || !mode) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= !blink_on_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: expected per-slot records are queued with the stimulus and popped per observed slot.
`timescale 1ns/1ps
module tb_disp_scan_ctrl;

  localparam int N      = 4;
  localparam int SLOT   = 8;
  localparam int BLANK  = 2;
  localparam int BLINKF = 2;
  localparam int DRV    = SLOT - BLANK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [11:0] codes_in;
  logic        update;
  logic [1:0]  cursor;
  logic [2:0]  seg_code;
  logic        seg_en;
  logic [3:0]  an_n;
  logic        frame_done;
`ifdef DISP_SCAN_DIM_EN
  logic        dim = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int carry_blank = 0;
  int fd_times[$];

  typedef struct {
    logic [3:0] an;
    logic [2:0] code;
    int         en_n;
    int         fd_n;
  } slot_t;
  slot_t exp_q[$];

  disp_scan_ctrl #(
    .N_DIGITS(N), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .BLINK_FRAMES(BLINKF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .codes_in(codes_in),
    .update(update), .cursor(cursor),
`ifdef DISP_SCAN_DIM_EN
    .dim(dim),
`endif
    .seg_code(seg_code), .seg_en(seg_en), .an_n(an_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) fd_times.push_back(cyc);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // Queue one frame of expected slots; off_digit gets no enabled cycles.
  function automatic void push_frame(input logic [11:0] codes, input int off_digit);
    for (int d = 0; d < N; d++) begin
      slot_t s;
      s.an   = ~(4'b0001 << d);
      s.code = codes[3*d +: 3];
      s.en_n = (d == off_digit) ? 0 : DRV;
      s.fd_n = (d == N - 1) ? 1 : 0;
      exp_q.push_back(s);
    end
  endfunction

  // Observe one slot at negedges: blank samples, then the run with one anode low.
  task automatic capture_slot(output logic [3:0] an, output logic [2:0] code,
                              output int blank_n, output int low_n, output int en_n,
                              output int fd_n, output bit stable, output bit ok);
    int guard = 0;
    blank_n = carry_blank; low_n = 0; en_n = 0; fd_n = 0; stable = 1'b1;
    @(negedge clk);
    while (an_n === 4'hF && guard < 100) begin
      blank_n++; guard++;
      @(negedge clk);
    end
    an = an_n; code = seg_code;
    while (an_n === an && guard < 100) begin
      low_n++; guard++;
      if (seg_en === 1'b1) en_n++;
      if (frame_done === 1'b1) fd_n++;
      if (seg_code !== code) stable = 1'b0;
      @(negedge clk);
    end
    carry_blank = (an_n === 4'hF) ? 1 : 0;
    ok = (guard < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; update = 1'b0; codes_in = '0; cursor = '0;
    repeat (3) @(negedge clk);
    $display("[reset] an_n=%b seg_en=%b seg_code=%b frame_done=%b", an_n, seg_en, seg_code, frame_done);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an_n: got %b expected 1111", an_n); end
    checks++; if (seg_en !== 1'b0) begin errors++; $display("FAIL reset_seg_en: got %b expected 0", seg_en); end
    checks++; if (seg_code !== 3'b000) begin errors++; $display("FAIL reset_seg_code: got %b expected 000", seg_code); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    rst_n = 1'b1;
    codes_in = 12'b100_011_010_001; update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    repeat (2) @(negedge clk);
    $display("[reset] idle after load an_n=%b", an_n);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL idle_an_n: got %b expected 1111", an_n); end
  endtask

  task automatic test_scan();
    logic [3:0] an; logic [2:0] code; int blank_n, low_n, en_n, fd_n; bit stable, ok; slot_t s;
    fd_times.delete();
    push_frame(12'b100_011_010_001, -1);
    push_frame(12'b100_011_010_001, -1);
    en = 1'b1; carry_blank = 0;
    for (int k = 0; k < 8; k++) begin
      capture_slot(an, code, blank_n, low_n, en_n, fd_n, stable, ok);
      s = exp_q.pop_front();
      $display("[scan] slot %0d an_n=%b code=%b blank=%0d low=%0d en=%0d fd=%0d", k, an, code, blank_n, low_n, en_n, fd_n);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL scan_timeout slot %0d: no slot within bound", k); end
      checks++; if (an !== s.an) begin errors++; $display("FAIL scan_anode slot %0d: got %b expected %b", k, an, s.an); end
      checks++; if (code !== s.code || !stable) begin errors++; $display("FAIL scan_code slot %0d: got %b stable=%0d expected %b", k, code, stable, s.code); end
      checks++; if (blank_n !== BLANK || low_n !== DRV) begin errors++; $display("FAIL scan_timing slot %0d: blank=%0d low=%0d expected %0d/%0d", k, blank_n, low_n, BLANK, DRV); end
      checks++; if (en_n !== s.en_n) begin errors++; $display("FAIL scan_seg_en slot %0d: got %0d expected %0d", k, en_n, s.en_n); end
      checks++; if (fd_n !== s.fd_n) begin errors++; $display("FAIL scan_frame_done slot %0d: got %0d expected %0d", k, fd_n, s.fd_n); end
    end
    $display("[scan] frame_done pulses=%0d", fd_times.size());
    checks++;
    if (fd_times.size() !== 2) begin
      errors++; $display("FAIL frame_pulses: got %0d expected 2", fd_times.size());
    end else if (fd_times[1] - fd_times[0] !== N * SLOT) begin
      errors++; $display("FAIL frame_period: got %0d expected %0d", fd_times[1] - fd_times[0], N * SLOT);
    end
  endtask

  task automatic test_buffered_update();
    logic [3:0] an; logic [2:0] code; int blank_n, low_n, en_n, fd_n; bit stable, ok; slot_t s;
    push_frame(12'b100_011_010_001, -1);
    push_frame(12'hFFF, -1);
    fork
      begin
        repeat (12) @(negedge clk);
        codes_in = 12'hFFF; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
      end
    join_none
    for (int k = 0; k < 8; k++) begin
      capture_slot(an, code, blank_n, low_n, en_n, fd_n, stable, ok);
      s = exp_q.pop_front();
      $display("[buffered] slot %0d an_n=%b code=%b blank=%0d low=%0d en=%0d", k, an, code, blank_n, low_n, en_n);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL buf_timeout slot %0d: no slot within bound", k); end
      checks++; if (an !== s.an) begin errors++; $display("FAIL buf_anode slot %0d: got %b expected %b", k, an, s.an); end
      checks++; if (code !== s.code || !stable) begin errors++; $display("FAIL buf_code slot %0d: got %b stable=%0d expected %b", k, code, stable, s.code); end
      checks++; if (en_n !== s.en_n) begin errors++; $display("FAIL buf_seg_en slot %0d: got %0d expected %0d", k, en_n, s.en_n); end
    end
  endtask

  task automatic test_coincident_update();
    logic [3:0] an; logic [2:0] code; int blank_n, low_n, en_n, fd_n; bit stable, ok; slot_t s;
    push_frame(12'hFFF, -1);
    push_frame(12'h249, -1);
    push_frame(12'h249, -1);
    fork
      begin
        int g = 0;
        @(negedge clk);
        while (frame_done !== 1'b1 && g < 200) begin g++; @(negedge clk); end
        codes_in = 12'h249; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
      end
    join_none
    for (int k = 0; k < 12; k++) begin
      capture_slot(an, code, blank_n, low_n, en_n, fd_n, stable, ok);
      s = exp_q.pop_front();
      $display("[coincident] slot %0d an_n=%b code=%b blank=%0d low=%0d en=%0d", k, an, code, blank_n, low_n, en_n);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL coin_timeout slot %0d: no slot within bound", k); end
      checks++; if (an !== s.an) begin errors++; $display("FAIL coin_anode slot %0d: got %b expected %b", k, an, s.an); end
      checks++; if (code !== s.code || !stable) begin errors++; $display("FAIL coin_code slot %0d: got %b stable=%0d expected %b", k, code, stable, s.code); end
      checks++; if (blank_n !== BLANK || low_n !== DRV) begin errors++; $display("FAIL coin_timing slot %0d: blank=%0d low=%0d expected %0d/%0d", k, blank_n, low_n, BLANK, DRV); end
    end
  endtask

  task automatic test_blink();
    logic [3:0] an; logic [2:0] code; int blank_n, low_n, en_n, fd_n; bit stable, ok; slot_t s;
    for (int f = 0; f < 7; f++) push_frame(12'h249, (f == 2 || f == 3) ? 2 : -1);
    mode = 1'b1; cursor = 2'd2;
    for (int k = 0; k < 28; k++) begin
      capture_slot(an, code, blank_n, low_n, en_n, fd_n, stable, ok);
      s = exp_q.pop_front();
      $display("[blink] slot %0d an_n=%b code=%b low=%0d en=%0d mode=%b", k, an, code, low_n, en_n, mode);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL blink_timeout slot %0d: no slot within bound", k); end
      checks++; if (an !== s.an || low_n !== DRV) begin errors++; $display("FAIL blink_anode slot %0d: got %b for %0d cycles expected %b for %0d", k, an, low_n, s.an, DRV); end
      checks++; if (en_n !== s.en_n) begin errors++; $display("FAIL blink_seg_en slot %0d: got %0d expected %0d", k, en_n, s.en_n); end
      if (k == 25) mode = 1'b0;
    end
  endtask

  task automatic test_disable();
    logic [3:0] an; logic [2:0] code; int blank_n, low_n, en_n, fd_n; bit stable, ok; slot_t s;
    capture_slot(an, code, blank_n, low_n, en_n, fd_n, stable, ok);
    $display("[disable] lead slot an_n=%b code=%b", an, code);
    checks++; if (an !== 4'b1110 || ok !== 1'b1) begin errors++; $display("FAIL dis_lead_anode: got %b expected 1110", an); end
    repeat (5) @(negedge clk);
    $display("[disable] digit1 cycle5 an_n=%b", an_n);
    checks++; if (an_n !== 4'b1101) begin errors++; $display("FAIL dis_pre_anode: got %b expected 1101", an_n); end
    en = 1'b0;
    @(negedge clk);
    $display("[disable] after en drop an_n=%b seg_en=%b", an_n, seg_en);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL dis_an_n: got %b expected 1111", an_n); end
    checks++; if (seg_en !== 1'b0) begin errors++; $display("FAIL dis_seg_en: got %b expected 0", seg_en); end
    repeat (3) @(negedge clk);
    checks++; if (an_n !== 4'hF || frame_done !== 1'b0) begin errors++; $display("FAIL dis_idle: an_n=%b frame_done=%b expected 1111/0", an_n, frame_done); end
    push_frame(12'h249, -1);
    en = 1'b1; carry_blank = 0;
    for (int k = 0; k < 4; k++) begin
      capture_slot(an, code, blank_n, low_n, en_n, fd_n, stable, ok);
      s = exp_q.pop_front();
      $display("[disable] restart slot %0d an_n=%b code=%b blank=%0d low=%0d", k, an, code, blank_n, low_n);
      checks++; if (an !== s.an || code !== s.code) begin errors++; $display("FAIL dis_restart slot %0d: got %b/%b expected %b/%b", k, an, code, s.an, s.code); end
      checks++; if (blank_n !== BLANK || low_n !== DRV || ok !== 1'b1) begin errors++; $display("FAIL dis_restart_timing slot %0d: blank=%0d low=%0d expected %0d/%0d", k, blank_n, low_n, BLANK, DRV); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] an; logic [2:0] code; int blank_n, low_n, en_n, fd_n; bit stable, ok;
    repeat (3) @(negedge clk);
    checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL ar_pre_anode: got %b expected 1110", an_n); end
    #2 rst_n = 1'b0;
    #1;
    $display("[async_reset] mid-drive an_n=%b seg_en=%b seg_code=%b", an_n, seg_en, seg_code);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL ar_an_n: got %b expected 1111", an_n); end
    checks++; if (seg_en !== 1'b0 || seg_code !== 3'b000) begin errors++; $display("FAIL ar_seg: seg_en=%b seg_code=%b expected 0/000", seg_en, seg_code); end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL ar_idle: got %b expected 1111", an_n); end
    en = 1'b1; carry_blank = 0;
    capture_slot(an, code, blank_n, low_n, en_n, fd_n, stable, ok);
    $display("[async_reset] first slot an_n=%b code=%b blank=%0d en=%0d", an, code, blank_n, en_n);
    checks++; if (an !== 4'b1110 || code !== 3'b000 || ok !== 1'b1) begin errors++; $display("FAIL ar_shadow: got %b/%b expected 1110/000", an, code); end
    checks++; if (blank_n !== BLANK || en_n !== DRV) begin errors++; $display("FAIL ar_timing: blank=%0d en=%0d expected %0d/%0d", blank_n, en_n, BLANK, DRV); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_buffered_update();
    test_coincident_update();
    test_blink();
    test_disable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 7-segment bank in the battleship game.
- The single column-letter encoder (inputs ch7/ch6/x,y,z → segments A–G) is shared across N_DIGITS anodes.
- The controller sequences digit select, presents each digit's 3-bit code and enable to the encoder, and inserts anti-ghost blanking between slots.
- In attack mode it blinks the cursor digit; code updates are double-buffered and applied only at frame boundaries.

Parameters:
N_DIGITS, 4, number of multiplexed digits (≥2)
SLOT_CYC, 50000, clock cycles per digit slot (blank + drive)
BLANK_CYC, 64, cycles of all-anodes-off at start of each slot; must be < SLOT_CYC
BLINK_FRAMES, 32, frames per blink half-period in attack mode

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  display on/off (ch7)
mode  in  1  0 = positioning, 1 = attack (ch6)
codes_in  in  3*N_DIGITS  packed per-digit codes {x,y,z}; digit i at [3i+2:3i]
update  in  1  one-cycle strobe: capture codes_in into pending buffer
cursor  in  $clog2(N_DIGITS)  digit index to blink in attack mode
seg_code  out  3  {x,y,z} to shared encoder
seg_en  out  1  drives encoder enable (ch7&ch6 path); 0 blanks segments
an_n  out  N_DIGITS  active-low anode selects, at most one low
frame_done  out  1  one-cycle pulse at end of last digit's slot

Behaviour:
- Reset (async, rst_n=0): state IDLE, an_n all 1, seg_en 0, seg_code 0, frame_done 0, idx 0, slot counter 0, shadow and pending buffers 0, pending_valid 0, blink counter 0, blink phase on.
- All outputs are registered; state updates on rising clk.
- States:
  - IDLE: outputs blanked. On en=1 → BLANK, idx=0, counter=0.
  - BLANK: an_n all 1, seg_en 0. Counter runs 0..BLANK_CYC-1, then → DRIVE.
  - DRIVE: an_n[idx]=0, seg_code=shadow[idx], seg_en=1 (except blink-off). Counter continues to SLOT_CYC-1. At slot end:
    - idx<N_DIGITS-1: idx+1 → BLANK.
    - idx=N_DIGITS-1: idx wraps to 0, frame_done=1 for exactly that cycle, blink counter advances → BLANK.
- Slot length is exactly SLOT_CYC cycles; frame length is N_DIGITS*SLOT_CYC.
- en=0 in any state: next cycle IDLE, outputs blanked, idx=0, counter=0. Pending data is retained; blink counter resets.
- Update buffering:
  - update=1 copies codes_in to pending and sets pending_valid.
  - A second update before frame end overwrites pending (last wins).
  - At the frame_done cycle, if pending_valid, shadow←pending and pending_valid←0.
  - update coincident with the frame_done cycle: codes_in goes directly to shadow that edge; pending_valid stays 0.
  - While in IDLE, update goes directly to shadow.
- Blink:
  - mode=1: cursor digit's seg_en is 0 during off phase; an_n still asserts. Phase toggles every BLINK_FRAMES frames; counter width $clog2(BLINK_FRAMES+1).
  - mode=0: counter 0, phase on.
  - mode change takes effect on the next cycle.
- cursor ≥ N_DIGITS: no digit blinks.
- Never more than one an_n bit low. The cycle after any DRIVE ends has an_n all 1.

Optional Feature:
DISP_SCAN_DIM_EN:
- Defined: adds input dim (1 bit). When dim=1, seg_en is held 0 during the second half of each DRIVE interval, i.e. counter ≥ BLANK_CYC+(SLOT_CYC-BLANK_CYC)/2. Anode timing is unchanged.
- Undefined: no dim port; seg_en is high for the full DRIVE interval.

Test Plan (N_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2, BLINK_FRAMES=2):
- Scan order: reset, en=1, codes_in=12'b100_011_010_001.
  - an_n sequence 1110,1101,1011,0111, each low 6 cycles after 2 all-1 cycles.
  - seg_code 001,010,011,100.
  - frame_done pulses every 32 cycles.
- Buffered update: mid-frame update with codes_in=12'hFFF. seg_code unchanged until frame_done; the next frame shows 111 on all digits.
- Coincident update: update on the frame_done cycle with codes 0x249. The first digit of the next frame shows 001; pending_valid stays 0.
- Blink: mode=1, cursor=2. Digit 2 seg_en=0 during frames 2–3 and 6–7 with an_n[2] still low; other digits unaffected. mode=0 restores it immediately.
- Disable mid-slot: drop en at cycle 5 of digit 1. Next cycle an_n=1111, seg_en=0. Re-enable restarts at digit 0 with a BLANK slot.
- Async reset mid-DRIVE: assert rst_n=0 without a clock edge. an_n goes to 1111 and seg_en to 0 immediately; after release, IDLE with shadow=0.
